// File: rtl/temp_sensor_spi.sv
// Periodic SPI master for a digital temperature sensor: reads one 16-bit frame per
// sample period and presents it clamped to an unsigned 6.4 fixed-point value.
module temp_sensor_spi #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       spi_miso,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic [5:0] temp,
    output logic [3:0] temp_frac,
    output logic       sample_valid,
    output logic       out_of_range,
    output logic       busy
);

    localparam int TW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        UPDATE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_cnt_next;
    logic [3:0]    bit_cnt;
    logic [3:0]    bit_cnt_next;
    logic          sclk_phase;
    logic          sclk_phase_next;
    logic [15:0]   shift_reg;
    logic          start;
    logic          div_done;
    logic          capture;
    logic          load;
    logic [11:0]   raw;
    logic [5:0]    conv_temp;
    logic [3:0]    conv_frac;
    logic          conv_oor;

    // Free-running sample timer; held at zero while sampling is disabled.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            timer <= '0;
        end else if (timer == TIMER_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign start    = enable && (timer == TIMER_LAST);
    assign div_done = (div_cnt == DIV_LAST);

    always_comb begin
        state_next      = state;
        div_cnt_next    = div_cnt;
        bit_cnt_next    = bit_cnt;
        sclk_phase_next = sclk_phase;
        capture         = 1'b0;
        load            = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = CS_SETUP;
                    div_cnt_next = '0;
                end
            end
            CS_SETUP: begin
                if (div_done) begin
                    state_next      = SHIFT;
                    div_cnt_next    = '0;
                    bit_cnt_next    = '0;
                    sclk_phase_next = 1'b0;
                end else begin
                    div_cnt_next = div_cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (div_done) begin
                    div_cnt_next = '0;
                    // MISO is taken on the same edge that drives SCLK high.
                    if (!sclk_phase) begin
                        sclk_phase_next = 1'b1;
                        capture         = 1'b1;
                    end else begin
                        sclk_phase_next = 1'b0;
                        if (bit_cnt == 4'd15) begin
                            state_next = CS_HOLD;
                        end else begin
                            bit_cnt_next = bit_cnt + 1'b1;
                        end
                    end
                end else begin
                    div_cnt_next = div_cnt + 1'b1;
                end
            end
            CS_HOLD: begin
                if (div_done) begin
                    state_next   = UPDATE;
                    div_cnt_next = '0;
                    load         = 1'b1;
                end else begin
                    div_cnt_next = div_cnt + 1'b1;
                end
            end
            UPDATE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Clamp the signed 12-bit reading into the monitor's unsigned 6.4 range.
    assign raw = shift_reg[15:4];

    always_comb begin
        conv_temp = raw[9:4];
        conv_frac = raw[3:0];
        conv_oor  = 1'b0;
        if (raw[11]) begin
            conv_temp = 6'd0;
            conv_frac = 4'd0;
            conv_oor  = 1'b1;
        end else if (raw[10]) begin
            conv_temp = 6'd63;
            conv_frac = 4'd15;
            conv_oor  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            sclk_phase   <= 1'b0;
            shift_reg    <= '0;
            temp         <= '0;
            temp_frac    <= '0;
            out_of_range <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_next;
            div_cnt      <= div_cnt_next;
            bit_cnt      <= bit_cnt_next;
            sclk_phase   <= sclk_phase_next;
            sample_valid <= load;
            if (capture) begin
                shift_reg <= {shift_reg[14:0], spi_miso};
            end
            if (load) begin
                temp         <= conv_temp;
                temp_frac    <= conv_frac;
                out_of_range <= conv_oor;
            end
        end
    end

    assign busy     = (state == CS_SETUP) || (state == SHIFT) || (state == CS_HOLD);
    assign spi_cs_n = !busy;
    assign spi_sclk = (state == SHIFT) && sclk_phase;

endmodule
